// File: rtl/lsu_seq_if.sv
// Bundle of the control-side request/response and memory-bus signals of the load/store sequencer.
// Handshakes: a request moves on a clock edge where req_valid && req_ready; resp_valid is a
// one-cycle pulse with no back-pressure; mem_read/mem_write stay high until a one-cycle mem_resp.
interface lsu_seq_if #(
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_fault;
    logic [31:0]       resp_rdata;
    logic [31:0]       mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [BE_W-1:0]   mem_byte_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_fault, resp_rdata,
               mem_addr, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_fault, resp_rdata,
               mem_addr, mem_read, mem_write, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/lsu_seq.sv
// Load/store sequencer: takes one RV32I load/store, runs one or two bus beats (split when an
// access crosses a bus word), then returns extended load data or a fault.
module lsu_seq #(
    parameter int          DATA_W      = 32,
    parameter bit          MISALIGN_EN = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;
    logic [DATA_W-1:0] beat1_q, beat1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [3:0] size_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic split_of(input logic [OFF_W-1:0] o, input logic [3:0] s);
        return (5'(o) + 5'(s)) > 5'(BE_W);
    endfunction

    function automatic logic illegal_of(input logic wr, input logic [2:0] f3);
        if (wr) return f3 >= 3'd3;
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    logic [OFF_W-1:0]  off;
    logic [3:0]        size;
    logic              split;
    logic              timeout_hit;
    logic [3:0]        hi_shift;
    logic [15:0]       lane_mask;
    logic [DATA_W-1:0] wd_ext;
    logic [31:0]       base_addr;
    logic [31:0]       raw;

    assign off         = addr_q[OFF_W-1:0];
    assign size        = size_of(funct3_q[1:0]);
    assign split       = split_of(off, size);
    assign hi_shift    = 4'(BE_W) - 4'(off);
    assign lane_mask   = (16'd1 << size) - 16'd1;
    assign wd_ext      = DATA_W'(wdata_q);
    assign base_addr   = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign raw         = 32'({beat1_q, beat0_q} >> {off, 3'b000});
    // The beat that reaches TIMEOUT waiting cycles gives up, unless mem_resp shows up that cycle.
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            beat0_q  <= '0;
            beat1_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            beat0_q  <= beat0_d;
            beat1_q  <= beat1_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fault_d  = fault_q;
        beat0_d  = beat0_q;
        beat1_d  = beat1_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = '0;
                    // Rejected requests skip the bus entirely and report straight away.
                    if (illegal_of(bus.req_write, bus.req_funct3) ||
                        (!MISALIGN_EN && split_of(bus.req_addr[OFF_W-1:0],
                                                  size_of(bus.req_funct3[1:0])))) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (bus.mem_resp) begin
                    cnt_d = '0;
                    if (state_q == BEAT0) begin
                        beat0_d = bus.mem_rdata;
                        state_d = split ? BEAT1 : RESP;
                    end else begin
                        beat1_d = bus.mem_rdata;
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready       = (state_q == IDLE);
        bus.resp_valid      = (state_q == RESP);
        bus.resp_fault      = (state_q == RESP) && fault_q;
        bus.resp_rdata      = 32'd0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_addr        = 32'd0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        if (state_q == BEAT0) begin
            bus.mem_read        = !write_q;
            bus.mem_write       = write_q;
            bus.mem_addr        = base_addr;
            bus.mem_byte_enable = BE_W'(lane_mask << off);
            bus.mem_wdata       = wd_ext << {off, 3'b000};
        end else if (state_q == BEAT1) begin
            bus.mem_read        = !write_q;
            bus.mem_write       = write_q;
            bus.mem_addr        = base_addr + 32'(BE_W);
            bus.mem_byte_enable = BE_W'(lane_mask >> hi_shift);
            bus.mem_wdata       = wd_ext >> {hi_shift, 3'b000};
        end
        if ((state_q == RESP) && !fault_q && !write_q) begin
            case (funct3_q)
                3'b000:  bus.resp_rdata = {{24{raw[7]}}, raw[7:0]};
                3'b001:  bus.resp_rdata = {{16{raw[15]}}, raw[15:0]};
                3'b100:  bus.resp_rdata = {24'd0, raw[7:0]};
                3'b101:  bus.resp_rdata = {16'd0, raw[15:0]};
                default: bus.resp_rdata = raw;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: three configurations (32-bit split/timeout, 32-bit no-split, 64-bit).
module tb_lsu_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_valid_v[3];
    logic        mem_resp_v[3];
    logic [63:0] mem_rdata_v[3];

    logic        req_ready_w[3], resp_valid_w[3], resp_fault_w[3], mem_read_w[3], mem_write_w[3];
    logic [31:0] resp_rdata_w[3], mem_addr_w[3];
    logic [7:0]  be_w[3];
    logic [63:0] wdata_w[3];
    logic [1:0]  dbg_w[3];

    lsu_seq_if #(.DATA_W(32)) if_a ();
    lsu_seq_if #(.DATA_W(32)) if_b ();
    lsu_seq_if #(.DATA_W(64)) if_c ();

    lsu_seq #(.DATA_W(32), .MISALIGN_EN(1'b1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .dbg_state(dbg_w[0]));
    lsu_seq #(.DATA_W(32), .MISALIGN_EN(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .dbg_state(dbg_w[1]));
    lsu_seq #(.DATA_W(64), .MISALIGN_EN(1'b1), .TIMEOUT(255)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c), .dbg_state(dbg_w[2]));

    assign if_a.req_valid = req_valid_v[0];
    assign if_b.req_valid = req_valid_v[1];
    assign if_c.req_valid = req_valid_v[2];
    assign if_a.req_write = req_write;   assign if_b.req_write = req_write;   assign if_c.req_write = req_write;
    assign if_a.req_funct3 = req_funct3; assign if_b.req_funct3 = req_funct3; assign if_c.req_funct3 = req_funct3;
    assign if_a.req_addr = req_addr;     assign if_b.req_addr = req_addr;     assign if_c.req_addr = req_addr;
    assign if_a.req_wdata = req_wdata;   assign if_b.req_wdata = req_wdata;   assign if_c.req_wdata = req_wdata;
    assign if_a.mem_resp = mem_resp_v[0];
    assign if_b.mem_resp = mem_resp_v[1];
    assign if_c.mem_resp = mem_resp_v[2];
    assign if_a.mem_rdata = mem_rdata_v[0][31:0];
    assign if_b.mem_rdata = mem_rdata_v[1][31:0];
    assign if_c.mem_rdata = mem_rdata_v[2];

    assign req_ready_w[0] = if_a.req_ready;   assign req_ready_w[1] = if_b.req_ready;   assign req_ready_w[2] = if_c.req_ready;
    assign resp_valid_w[0] = if_a.resp_valid; assign resp_valid_w[1] = if_b.resp_valid; assign resp_valid_w[2] = if_c.resp_valid;
    assign resp_fault_w[0] = if_a.resp_fault; assign resp_fault_w[1] = if_b.resp_fault; assign resp_fault_w[2] = if_c.resp_fault;
    assign resp_rdata_w[0] = if_a.resp_rdata; assign resp_rdata_w[1] = if_b.resp_rdata; assign resp_rdata_w[2] = if_c.resp_rdata;
    assign mem_read_w[0] = if_a.mem_read;     assign mem_read_w[1] = if_b.mem_read;     assign mem_read_w[2] = if_c.mem_read;
    assign mem_write_w[0] = if_a.mem_write;   assign mem_write_w[1] = if_b.mem_write;   assign mem_write_w[2] = if_c.mem_write;
    assign mem_addr_w[0] = if_a.mem_addr;     assign mem_addr_w[1] = if_b.mem_addr;     assign mem_addr_w[2] = if_c.mem_addr;
    assign be_w[0] = {4'd0, if_a.mem_byte_enable};
    assign be_w[1] = {4'd0, if_b.mem_byte_enable};
    assign be_w[2] = if_c.mem_byte_enable;
    assign wdata_w[0] = {32'd0, if_a.mem_wdata};
    assign wdata_w[1] = {32'd0, if_b.mem_wdata};
    assign wdata_w[2] = if_c.mem_wdata;

    // Scoreboard queues: resp {id, fault, rdata}; beat {id, write, addr, byte_enable, wdata}.
    logic [34:0]  exp_resp_q[$];
    logic [106:0] exp_beat_q[$];
    logic [34:0]  e_resp;
    logic [106:0] e_beat;
    logic         in_beat[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input int id, input logic wr, input logic [31:0] a,
                            input logic [7:0] be, input logic [63:0] wd);
        exp_beat_q.push_back({2'(id), wr, a, be, wd});
    endtask

    task automatic exp_resp(input int id, input logic fault, input logic [31:0] rd);
        exp_resp_q.push_back({2'(id), fault, rd});
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) in_beat[i] = 1'b0;
            if (resp_valid_w[i] === 1'b1) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected dut=%0d actual=resp_valid expected=none", i);
                end else begin
                    e_resp = exp_resp_q.pop_front();
                    check($sformatf("resp_dut%0d", i),
                          128'({2'(i), resp_fault_w[i], resp_rdata_w[i]}), 128'(e_resp));
                end
            end
            if ((mem_read_w[i] | mem_write_w[i]) === 1'b1) begin
                if (!in_beat[i]) begin
                    if (exp_beat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected dut=%0d actual=strobe expected=none", i);
                    end else begin
                        e_beat = exp_beat_q.pop_front();
                        check($sformatf("beat_dut%0d", i),
                              128'({2'(i), mem_write_w[i], mem_addr_w[i], be_w[i], wdata_w[i]}),
                              128'(e_beat));
                    end
                end
                in_beat[i] = !mem_resp_v[i];
            end else begin
                in_beat[i] = 1'b0;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int id, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        check($sformatf("req_ready_dut%0d", id), 128'(req_ready_w[id]), 128'(1));
        req_write = wr;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_valid_v[id] = 1'b1;
        settle(1);
        req_valid_v[id] = 1'b0;
    endtask

    task automatic mem_beat(input int id, input int delay, input logic [63:0] rd);
        int n = 0;
        while (!(mem_read_w[id] | mem_write_w[id]) && n < 50) begin
            settle(1);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL mem_wait dut=%0d actual=no_strobe expected=strobe", id);
        end else begin
            settle(delay);
            mem_resp_v[id] = 1'b1;
            mem_rdata_v[id] = rd;
            settle(1);
            mem_resp_v[id] = 1'b0;
            mem_rdata_v[id] = 64'd0;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid_v[i] = 1'b0;
            mem_resp_v[i] = 1'b0;
            mem_rdata_v[i] = 64'd0;
            in_beat[i] = 1'b0;
        end
        settle(3);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_dut%0d", i),
                  128'({req_ready_w[i], resp_valid_w[i], resp_fault_w[i], mem_read_w[i],
                        mem_write_w[i], mem_addr_w[i], be_w[i], wdata_w[i], resp_rdata_w[i]}),
                  128'({1'b1, 4'b0000, 32'd0, 8'd0, 64'd0, 32'd0}));

        // lw aligned, responds in the first beat cycle
        exp_beat(0, 0, 32'h100, 8'h0F, 64'd0);
        exp_resp(0, 0, 32'hDEADBEEF);
        issue(0, 0, 3'b010, 32'h100, 32'd0);
        mem_beat(0, 0, 64'hDEADBEEF);
        check("lat_aligned", 128'(resp_valid_w[0]), 128'(1));
        settle(2);

        // lb / lbu of top byte
        exp_beat(0, 0, 32'h100, 8'h08, 64'd0);
        exp_resp(0, 0, 32'hFFFFFF80);
        issue(0, 0, 3'b000, 32'h103, 32'd0);
        mem_beat(0, 0, 64'h80123456);
        settle(2);
        exp_beat(0, 0, 32'h100, 8'h08, 64'd0);
        exp_resp(0, 0, 32'h00000080);
        issue(0, 0, 3'b100, 32'h103, 32'd0);
        mem_beat(0, 0, 64'h80123456);
        settle(2);

        // sb at byte 1
        exp_beat(0, 1, 32'h100, 8'h02, 64'h34567800);
        exp_resp(0, 0, 32'd0);
        issue(0, 1, 3'b000, 32'h101, 32'h12345678);
        mem_beat(0, 1, 64'd0);
        settle(2);

        // sw split across words
        exp_beat(0, 1, 32'h100, 8'h0C, 64'hCCDD0000);
        exp_beat(0, 1, 32'h104, 8'h03, 64'h0000AABB);
        exp_resp(0, 0, 32'd0);
        issue(0, 1, 3'b010, 32'h102, 32'hAABBCCDD);
        mem_beat(0, 0, 64'd0);
        mem_beat(0, 2, 64'd0);
        settle(2);

        // lw split across words
        exp_beat(0, 0, 32'h100, 8'h08, 64'd0);
        exp_beat(0, 0, 32'h104, 8'h07, 64'd0);
        exp_resp(0, 0, 32'h44332211);
        issue(0, 0, 3'b010, 32'h103, 32'd0);
        mem_beat(0, 0, 64'h11AAAAAA);
        mem_beat(0, 0, 64'hBB443322);
        settle(2);

        // illegal funct3: load 3, store 4
        exp_resp(0, 1, 32'd0);
        issue(0, 0, 3'b011, 32'h100, 32'd0);
        check("illegal_ld", 128'({mem_read_w[0], mem_write_w[0], resp_valid_w[0]}), 128'(3'b001));
        settle(2);
        exp_resp(0, 1, 32'd0);
        issue(0, 1, 3'b100, 32'h100, 32'h55);
        check("illegal_st", 128'({mem_read_w[0], mem_write_w[0], resp_valid_w[0]}), 128'(3'b001));
        settle(2);

        // timeout after 4 beat cycles
        exp_beat(0, 0, 32'h200, 8'h0F, 64'd0);
        exp_resp(0, 1, 32'd0);
        issue(0, 0, 3'b010, 32'h200, 32'd0);
        n = 0;
        while (mem_read_w[0] && n < 20) begin
            n++;
            settle(1);
        end
        check("timeout_cycles", 128'(n), 128'(4));
        check("timeout_resp", 128'({resp_valid_w[0], resp_fault_w[0]}), 128'(2'b11));
        settle(1);
        check("timeout_ready", 128'(req_ready_w[0]), 128'(1));
        settle(1);

        // mem_resp on the timeout cycle wins
        exp_beat(0, 0, 32'h204, 8'h0F, 64'd0);
        exp_resp(0, 0, 32'h0BADF00D);
        issue(0, 0, 3'b010, 32'h204, 32'd0);
        mem_beat(0, 3, 64'h0BADF00D);
        settle(2);

        // no-split config: misaligned lh faults with no bus cycle
        exp_resp(1, 1, 32'd0);
        issue(1, 0, 3'b001, 32'h103, 32'd0);
        check("misalign_fault", 128'({mem_read_w[1], resp_valid_w[1], resp_fault_w[1]}), 128'(3'b011));
        settle(2);
        exp_beat(1, 0, 32'h100, 8'h06, 64'd0);
        exp_resp(1, 0, 32'hFFFFF00F);
        issue(1, 0, 3'b001, 32'h101, 32'd0);
        mem_beat(1, 0, 64'h00F00F00);
        settle(2);
        // timeout disabled: a slow response still completes cleanly
        exp_beat(1, 0, 32'h100, 8'h0C, 64'd0);
        exp_resp(1, 0, 32'h0000BEEF);
        issue(1, 0, 3'b101, 32'h102, 32'd0);
        mem_beat(1, 10, 64'hBEEF1234);
        settle(2);

        // 64-bit bus
        exp_beat(2, 0, 32'h108, 8'hF0, 64'd0);
        exp_resp(2, 0, 32'h12345678);
        issue(2, 0, 3'b010, 32'h10C, 32'd0);
        mem_beat(2, 0, 64'h12345678_00000000);
        settle(2);
        exp_beat(2, 1, 32'h108, 8'h3C, 64'h0000AABB_CCDD0000);
        exp_resp(2, 0, 32'd0);
        issue(2, 1, 3'b010, 32'h10A, 32'hAABBCCDD);
        mem_beat(2, 0, 64'd0);
        settle(2);
        exp_beat(2, 0, 32'h108, 8'h80, 64'd0);
        exp_beat(2, 0, 32'h110, 8'h01, 64'd0);
        exp_resp(2, 0, 32'h0000CDAB);
        issue(2, 0, 3'b101, 32'h10F, 32'd0);
        mem_beat(2, 0, 64'hAB00000000000000);
        mem_beat(2, 1, 64'h00000000000000CD);
        settle(2);

        // reset in the middle of BEAT1: no response may follow
        exp_beat(2, 0, 32'h108, 8'h80, 64'd0);
        exp_beat(2, 0, 32'h110, 8'h01, 64'd0);
        issue(2, 0, 3'b101, 32'h10F, 32'd0);
        mem_beat(2, 0, 64'hAB00000000000000);
        check("beat1_before_rst", 128'(mem_read_w[2]), 128'(1));
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        check("rst_abort", 128'({mem_read_w[2], mem_write_w[2], req_ready_w[2], resp_valid_w[2]}),
              128'(4'b0010));
        settle(6);

        check("resp_q_empty", 128'(exp_resp_q.size()), 128'(0));
        check("beat_q_empty", 128'(exp_beat_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
